pattern_tx: RTL and testbench
=============================

# pattern_tx

Serial pattern transmitter. It emits a fixed, parameterised bit pattern MSB-first on a single serial line, one bit per clock, repeated a programmed number of times back-to-back. It is the stimulus end of the serial sequence-detector path: its `sout` drives the detector's serial input `j`, and each transmitted frame of the default pattern 10110 produces one detector hit. Control is a start/done handshake with synchronous abort.

## Interface
- `PAT_W`, default 5: pattern length in bits; must be ≥ 2.
- `PATTERN`, default 5'b10110: the pattern; bit `PAT_W-1` is sent first.
- `REP_W`, default 4: width of the repeat count.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request to transmit; sampled only in IDLE.
- `reps`  in  REP_W  number of frames to send; captured together with `start`.
- `abort`  in  1  synchronous abort; has priority over all other inputs except `rst`.
- `sout`  out  1  serial data bit.
- `sout_vld`  out  1  high while `sout` carries a pattern bit.
- `busy`  out  1  high in SHIFT.
- `done`  out  1  one-cycle pulse after the last bit of the last frame.
- `frames_left`  out  REP_W  frames remaining, including the current frame.

## Operation
- States: IDLE, SHIFT, DONE. Moore machine; all outputs are registered or decoded from state only.
- Reset values: state IDLE; `sout`, `sout_vld`, `busy` and `done` all 0; `frames_left` 0; bit index 0.
- **IDLE**
  - `start`=1 and `reps`≠0: capture `reps` into `frames_left`, set bit index to 0, go to SHIFT.
  - `start`=1 and `reps`=0: go directly to DONE. No bits are sent.
  - `start`=0: stay in IDLE.
- **SHIFT**
  - `sout` = `PATTERN[PAT_W-1-idx]`; `sout_vld`=1; `busy`=1.
  - When `idx` reaches the last bit of a frame:
    - If `frames_left`>1: decrement `frames_left`, set `idx` to 0, stay in SHIFT. The next frame follows with no gap bit.
    - If `frames_left`=1: set `frames_left` to 0 and go to DONE.
- **DONE**
  - `done`=1; `busy`=0; `sout_vld`=0; `sout`=0.
  - Always returns to IDLE on the next cycle.
  - `start` in DONE is ignored; the requester must hold or reassert it in IDLE.
- **Abort**
  - `abort`=1 in any state: next state is IDLE, `frames_left` is cleared, and `done` is not pulsed.
  - In SHIFT, the bit being driven in the abort cycle is the last bit emitted.
  - `abort` and `start` asserted together in IDLE: stay in IDLE.
- `start` is ignored while in SHIFT; the in-flight transfer is unaffected.
- `sout` is 0 whenever `sout_vld`=0.
- Asserting `rst` mid-frame returns the block to its reset values immediately, without waiting for a clock edge.

## Timing
- Latency from start to first bit: `start` sampled at edge N → first bit valid from edge N through edge N+1.
- Frame length: F = `PAT_W` bits, or `PAT_W`+1 bits with parity enabled.
- Transfer length: `reps`×F consecutive valid cycles with no bubbles.
- `done` is high for exactly one cycle, immediately after the last valid bit.
- IDLE is re-entered one cycle later, so the earliest following `start` is sampled one cycle after `done`.
- Start-to-done latency: `reps`×F + 1 cycles. With `reps`=0, `done` is high in the cycle after `start` is sampled.

## Configuration
- `PATTERN_TX_PARITY_EN`
  - **Defined:** after the last pattern bit of each frame, one even-parity bit is sent with `sout_vld`=1. Its value is the XOR of all `PATTERN` bits. F = `PAT_W`+1.
  - **Undefined:** no parity logic is present and F = `PAT_W`.

## Test plan
- Reset: assert `rst` mid-SHIFT → all outputs are 0 and the state is IDLE without waiting for a clock edge. After release, the block stays idle until `start`.
- Single frame, parity off, defaults: `start`=1, `reps`=1 → `sout` = 1,0,1,1,0 on 5 consecutive valid cycles, then `done` for one cycle. The connected detector raises `w` exactly once.
- Back-to-back frames: `reps`=3 → 15 contiguous valid bits (10110 three times) and `done` at cycle 16. `frames_left` steps 3→2→1→0, and detector `w` pulses 3 times.
- Zero reps and ignored start: `reps`=0 → `done` in the next cycle with no valid bits. `start` pulsed during SHIFT or DONE → no effect on the transfer.
- Abort: `abort` at the 3rd bit of frame 2 of 3 → next cycle in IDLE, `sout_vld`=0, `frames_left`=0, and no `done` pulse.
- Parity build (`PATTERN_TX_PARITY_EN` defined): `reps`=2 → `sout` = 1,0,1,1,0,1 twice (12 valid cycles), then `done`.

Source files
------------

// File: rtl/pattern_tx.sv
// pattern_tx: serial pattern transmitter.
//
// Sends PATTERN MSB-first on sout, one bit per clock, repeated `reps` times
// back-to-back with no gap bits, then pulses done for one cycle. The default
// pattern 10110 gives one sequence-detector hit per transmitted frame.
//
// Configuration macro: PATTERN_TX_PARITY_EN
//   defined   - an even-parity bit (XOR of all PATTERN bits) follows each frame
//   undefined - frames are exactly PAT_W bits and no parity logic exists
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        transfer request, sampled only in IDLE
//   reps         frame count, captured together with start
//   abort        synchronous abort, overrides everything except rst
//   sout         serial data bit (0 when not valid)
//   sout_vld     sout carries a frame bit
//   busy         high while shifting
//   done         one-cycle pulse after the last bit of the last frame
//   frames_left  frames remaining, including the current one
module pattern_tx #(
    parameter int             PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b10110,
    parameter int             REP_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [REP_W-1:0] reps,
    input  logic             abort,
    output logic             sout,
    output logic             sout_vld,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] frames_left
);

`ifdef PATTERN_TX_PARITY_EN
    localparam int F = PAT_W + 1;
    localparam logic [F-1:0] FRAME = {PATTERN, ^PATTERN};
`else
    localparam int F = PAT_W;
    localparam logic [F-1:0] FRAME = PATTERN;
`endif

    localparam int IDX_W = $clog2(F);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(F - 1);

    // Bit-reversed frame so the bit sent at index i is simply FRAME_REV[i].
    function automatic logic [F-1:0] reverse_bits(input logic [F-1:0] v);
        logic [F-1:0] r;
        for (int k = 0; k < F; k++) begin
            r[k] = v[F-1-k];
        end
        return r;
    endfunction

    localparam logic [F-1:0] FRAME_REV = reverse_bits(FRAME);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] frames_left_q, frames_left_d;
    logic             sout_q, sout_d;
    logic             sout_vld_q, sout_vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Outputs are computed alongside the next state and registered, so the
    // bit for index idx_d appears on sout in the same cycle the FSM holds it.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        frames_left_d = frames_left_q;
        sout_d        = 1'b0;
        sout_vld_d    = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;

        if (abort) begin
            state_d       = IDLE;
            idx_d         = '0;
            frames_left_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (reps != '0) begin
                            state_d       = SHIFT;
                            idx_d         = '0;
                            frames_left_d = reps;
                            sout_d        = FRAME_REV[0];
                            sout_vld_d    = 1'b1;
                            busy_d        = 1'b1;
                        end else begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (idx_q == LAST_IDX) begin
                        if (frames_left_q > REP_W'(1)) begin
                            // Next frame starts immediately: no gap bit.
                            frames_left_d = frames_left_q - REP_W'(1);
                            idx_d         = '0;
                            sout_d        = FRAME_REV[0];
                            sout_vld_d    = 1'b1;
                            busy_d        = 1'b1;
                        end else begin
                            frames_left_d = '0;
                            idx_d         = '0;
                            state_d       = DONE;
                            done_d        = 1'b1;
                        end
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        sout_d     = FRAME_REV[idx_d];
                        sout_vld_d = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            frames_left_q <= '0;
            sout_q        <= 1'b0;
            sout_vld_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            frames_left_q <= frames_left_d;
            sout_q        <= sout_d;
            sout_vld_q    <= sout_vld_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign sout        = sout_q;
    assign sout_vld    = sout_vld_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frames_left = frames_left_q;

endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: self-checking bench for pattern_tx with a cycle-level
// reference model built from the frame/transfer rules.
module tb_pattern_tx;

    localparam int             PAT_W   = 5;
    localparam logic [PAT_W-1:0] PATTERN = 5'b10110;
    localparam int             REP_W   = 4;
`ifdef PATTERN_TX_PARITY_EN
    localparam int F = PAT_W + 1;
`else
    localparam int F = PAT_W;
`endif

    // {sout, sout_vld, busy, done, frames_left}
    typedef logic [REP_W+3:0] obs_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [REP_W-1:0] reps = '0;
    logic             abort = 1'b0;
    logic             sout;
    logic             sout_vld;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] frames_left;

    int checks = 0;
    int errors = 0;

    pattern_tx #(
        .PAT_W  (PAT_W),
        .PATTERN(PATTERN),
        .REP_W  (REP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .reps       (reps),
        .abort      (abort),
        .sout       (sout),
        .sout_vld   (sout_vld),
        .busy       (busy),
        .done       (done),
        .frames_left(frames_left)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic obs_t observe();
        return {sout, sout_vld, busy, done, frames_left};
    endfunction

    // Bit number b (0 = first sent) of a frame; the bit after the pattern is
    // the even-parity bit when parity is built in.
    function automatic logic frame_bit(input int b);
        logic [PAT_W-1:0] p;
        p = PATTERN;
        if (b < PAT_W) return p[PAT_W-1-b];
        return ^p;
    endfunction

    // Expected per-cycle outputs starting the cycle after start is sampled.
    // abort_at >= 0 truncates the stream after that cycle.
    function automatic void build_expected(input int r, input int abort_at,
                                           output obs_t q[$], output int last_active);
        q = {};
        for (int f = 0; f < r; f++) begin
            for (int b = 0; b < F; b++) begin
                q.push_back({frame_bit(b), 1'b1, 1'b1, 1'b0, REP_W'(r - f)});
            end
        end
        q.push_back({1'b0, 1'b0, 1'b0, 1'b1, REP_W'(0)});
        if (abort_at >= 0) begin
            while (q.size() > abort_at + 1) void'(q.pop_back());
        end
        last_active = q.size() - 1;
        q.push_back('0);
        q.push_back('0);
    endfunction

    task automatic run_transfer(input string name, input int r, input int abort_at,
                                input bit noisy);
        obs_t exp_q[$];
        int   last_active;
        obs_t got;
        build_expected(r, abort_at, exp_q, last_active);
        reps  = REP_W'(r);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        reps  = REP_W'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            got = observe();
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: got {sout,vld,busy,done,fl}=%b expected %b",
                         name, i, got, exp_q[i]);
            end
            if (i == abort_at) abort = 1'b1;
            if (noisy && i <= last_active && $urandom_range(0, 2) == 0) begin
                start = 1'b1;
                reps  = REP_W'($urandom);
            end
            @(posedge clk);
            #1;
            abort = 1'b0;
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        obs_t got;
        #3;
        got = observe();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("[TB] FAIL reset_initial: got %b expected 0", got);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Start a 3-frame transfer, then hit reset mid-frame between edges.
        reps  = REP_W'(3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        got = observe();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("[TB] FAIL reset_async_midframe: got %b expected 0", got);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            got = observe();
            checks++;
            if (got !== '0) begin
                errors++;
                $display("[TB] FAIL reset_stays_idle: got %b expected 0", got);
            end
        end
    endtask

    task automatic test_single_frame();
        run_transfer("single_frame", 1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_transfer("back_to_back", 3, -1, 1'b0);
        run_transfer("back_to_back_max", (1 << REP_W) - 1, -1, 1'b0);
    endtask

    task automatic test_zero_reps();
        run_transfer("zero_reps", 0, -1, 1'b0);
        run_transfer("zero_reps_noisy", 0, -1, 1'b1);
    endtask

    task automatic test_ignored_start();
        run_transfer("ignored_start", 2, -1, 1'b1);
    endtask

    task automatic test_abort();
        obs_t got;
        // 3rd bit of frame 2 of 3.
        run_transfer("abort_midframe", 3, F + 2, 1'b0);
        run_transfer("abort_first_bit", 2, 0, 1'b0);
        run_transfer("abort_in_done", 1, F, 1'b0);
        // start and abort together in IDLE must not launch a transfer.
        reps  = REP_W'(2);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) begin
            got = observe();
            checks++;
            if (got !== '0) begin
                errors++;
                $display("[TB] FAIL abort_with_start_idle: got %b expected 0", got);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        int r;
        int ab;
        for (int n = 0; n < 30; n++) begin
            r  = $urandom_range(0, 6);
            ab = -1;
            if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, r * F);
            run_transfer($sformatf("random_%0d", n), r, ab, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_zero_reps();
        test_ignored_start();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
